// File: rtl/vga_rect_compositor_if.sv
// Register-write port of the rectangle compositor: one field write per cycle
// into the pending parameter bank.
interface vga_rect_compositor_if #(
    parameter int IDX_BITWIDTH  = 2,
    parameter int DATA_BITWIDTH = 24
);
    logic                     i_wr_en;
    logic [IDX_BITWIDTH-1:0]  i_wr_rect;
    logic [2:0]               i_wr_field;
    logic [DATA_BITWIDTH-1:0] i_wr_data;

    modport master (output i_wr_en, i_wr_rect, i_wr_field, i_wr_data);
    modport slave  (input  i_wr_en, i_wr_rect, i_wr_field, i_wr_data);
endinterface

// File: rtl/vga_rect_compositor.sv
// VGA raster generator that composites NUM_RECTS prioritised filled rectangles
// over a background colour; parameters are double-banked and swap at frame end.
module vga_rect_compositor #(
    parameter int WIDTH          = 800,
    parameter int HEIGHT         = 525,
    parameter int WIDTH_VISIBLE  = 640,
    parameter int HEIGHT_VISIBLE = 480,
    parameter int FRONT_PORCH_X  = 16,
    parameter int BACK_PORCH_X   = 48,
    parameter int FRONT_PORCH_Y  = 10,
    parameter int BACK_PORCH_Y   = 33,
    parameter int NUM_RECTS      = 4,
    parameter int PIXEL_BITWIDTH = 11,
    parameter int RGB_BITWIDTH   = 8,
    parameter int IDX_BITWIDTH   = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    vga_rect_compositor_if.slave      wr_bus,
    output logic [PIXEL_BITWIDTH-1:0] o_vga_x,
    output logic [PIXEL_BITWIDTH-1:0] o_vga_y,
    output logic [RGB_BITWIDTH-1:0]   o_vga_red,
    output logic [RGB_BITWIDTH-1:0]   o_vga_green,
    output logic [RGB_BITWIDTH-1:0]   o_vga_blue,
    output logic                      o_vga_hsync,
    output logic                      o_vga_vsync,
    output logic                      o_visible,
    output logic                      o_frame_start
);
    localparam int P = PIXEL_BITWIDTH;
    localparam int C = 3 * RGB_BITWIDTH;
    localparam int HSYNC_W = WIDTH - WIDTH_VISIBLE - FRONT_PORCH_X - BACK_PORCH_X;
    localparam int VSYNC_W = HEIGHT - HEIGHT_VISIBLE - FRONT_PORCH_Y - BACK_PORCH_Y;

    localparam logic [P-1:0] X_LAST   = P'(WIDTH - 1);
    localparam logic [P-1:0] Y_LAST   = P'(HEIGHT - 1);
    localparam logic [P-1:0] X_VIS    = P'(WIDTH_VISIBLE);
    localparam logic [P-1:0] Y_VIS    = P'(HEIGHT_VISIBLE);
    localparam logic [P-1:0] HS_START = P'(WIDTH_VISIBLE + FRONT_PORCH_X);
    localparam logic [P-1:0] HS_END   = P'(WIDTH_VISIBLE + FRONT_PORCH_X + HSYNC_W);
    localparam logic [P-1:0] VS_START = P'(HEIGHT_VISIBLE + FRONT_PORCH_Y);
    localparam logic [P-1:0] VS_END   = P'(HEIGHT_VISIBLE + FRONT_PORCH_Y + VSYNC_W);

    typedef enum logic [2:0] {
        FIELD_X      = 3'd0,
        FIELD_Y      = 3'd1,
        FIELD_W      = 3'd2,
        FIELD_H      = 3'd3,
        FIELD_COLOUR = 3'd4,
        FIELD_EN     = 3'd5,
        FIELD_BG     = 3'd6,
        FIELD_RSVD   = 3'd7
    } field_e;

    typedef struct packed {
        logic [P-1:0] x;
        logic [P-1:0] y;
        logic [P-1:0] w;
        logic [P-1:0] h;
        logic [C-1:0] colour;
        logic         en;
    } rect_t;

    logic [P-1:0] cx_q, cx_d, cy_q, cy_d;
    logic         commit;

    rect_t        pend_q [NUM_RECTS];
    rect_t        pend_d [NUM_RECTS];
    rect_t        act_q  [NUM_RECTS];
    logic [C-1:0] pend_bg_q, pend_bg_d, act_bg_q;

    logic [NUM_RECTS-1:0] s1_hit_q, s1_hit_d;
    logic [P-1:0]         s1_x_q, s1_y_q;
    logic                 s1_vis_q, s1_vis_d;
    logic                 s1_hsync_q, s1_hsync_d, s1_vsync_q, s1_vsync_d;
    logic                 s1_fs_q;

    logic [C-1:0] colour_d;
    logic [P-1:0] out_x_q, out_y_q;
    logic [C-1:0] out_rgb_q;
    logic         out_hsync_q, out_vsync_q, out_vis_q, out_fs_q;

    always_comb begin
        cx_d = (cx_q == X_LAST) ? '0 : cx_q + 1'b1;
        cy_d = cy_q;
        if (cx_q == X_LAST) cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
    end

    assign commit = (cx_q == X_LAST) && (cy_q == Y_LAST);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pend_d    = pend_q;
        pend_bg_d = pend_bg_q;
        if (wr_bus.i_wr_en) begin
            if (field_e'(wr_bus.i_wr_field) == FIELD_BG) begin
                pend_bg_d = wr_bus.i_wr_data[C-1:0];
            end else if (int'(wr_bus.i_wr_rect) < NUM_RECTS) begin
                case (field_e'(wr_bus.i_wr_field))
                    FIELD_X:      pend_d[wr_bus.i_wr_rect].x      = wr_bus.i_wr_data[P-1:0];
                    FIELD_Y:      pend_d[wr_bus.i_wr_rect].y      = wr_bus.i_wr_data[P-1:0];
                    FIELD_W:      pend_d[wr_bus.i_wr_rect].w      = wr_bus.i_wr_data[P-1:0];
                    FIELD_H:      pend_d[wr_bus.i_wr_rect].h      = wr_bus.i_wr_data[P-1:0];
                    FIELD_COLOUR: pend_d[wr_bus.i_wr_rect].colour = wr_bus.i_wr_data[C-1:0];
                    FIELD_EN:     pend_d[wr_bus.i_wr_rect].en     = wr_bus.i_wr_data[0];
                    default:      ;
                endcase
            end
        end
    end

    // Extents summed one bit wider so rectangles past the coordinate range clip instead of wrapping.
    always_comb begin
        s1_hit_d = '0;
        for (int k = 0; k < NUM_RECTS; k++) begin
            s1_hit_d[k] = act_q[k].en
                       && (cx_q >= act_q[k].x) && (cy_q >= act_q[k].y)
                       && ({1'b0, cx_q} < ({1'b0, act_q[k].x} + {1'b0, act_q[k].w}))
                       && ({1'b0, cy_q} < ({1'b0, act_q[k].y} + {1'b0, act_q[k].h}));
        end
        s1_vis_d   = (cx_q < X_VIS) && (cy_q < Y_VIS);
        s1_hsync_d = !((cx_q >= HS_START) && (cx_q < HS_END));
        s1_vsync_d = !((cy_q >= VS_START) && (cy_q < VS_END));
    end

    // Walking down from the highest index lets the lowest-index hit overwrite last.
    always_comb begin
        colour_d = act_bg_q;
        for (int k = NUM_RECTS - 1; k >= 0; k--) begin
            if (s1_hit_q[k]) colour_d = act_q[k].colour;
        end
        if (!s1_vis_q) colour_d = '0;
    end

    // NOTE: both banks are small flop arrays, not RAM, so they are cleared on reset to guarantee every enable reads 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cx_q      <= '0;
            cy_q      <= '0;
            for (int k = 0; k < NUM_RECTS; k++) begin
                pend_q[k] <= '0;
                act_q[k]  <= '0;
            end
            pend_bg_q <= '0;
            act_bg_q  <= '0;
        end else begin
            // NOTE: non-blocking assignment makes the commit copy the pending bank as it was before this cycle's write.
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            pend_q    <= pend_d;
            pend_bg_q <= pend_bg_d;
            if (commit) begin
                act_q    <= pend_q;
                act_bg_q <= pend_bg_q;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_hit_q    <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_vis_q    <= 1'b0;
            s1_hsync_q  <= 1'b1;
            s1_vsync_q  <= 1'b1;
            s1_fs_q     <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_rgb_q   <= '0;
            out_hsync_q <= 1'b1;
            out_vsync_q <= 1'b1;
            out_vis_q   <= 1'b0;
            out_fs_q    <= 1'b0;
        end else begin
            s1_hit_q    <= s1_hit_d;
            s1_x_q      <= cx_q;
            s1_y_q      <= cy_q;
            s1_vis_q    <= s1_vis_d;
            s1_hsync_q  <= s1_hsync_d;
            s1_vsync_q  <= s1_vsync_d;
            s1_fs_q     <= (cx_q == '0) && (cy_q == '0);
            out_x_q     <= s1_x_q;
            out_y_q     <= s1_y_q;
            out_rgb_q   <= colour_d;
            out_hsync_q <= s1_hsync_q;
            out_vsync_q <= s1_vsync_q;
            out_vis_q   <= s1_vis_q;
            out_fs_q    <= s1_fs_q;
        end
    end

    assign o_vga_x       = out_x_q;
    assign o_vga_y       = out_y_q;
    assign o_vga_red     = out_rgb_q[C-1:2*RGB_BITWIDTH];
    assign o_vga_green   = out_rgb_q[2*RGB_BITWIDTH-1:RGB_BITWIDTH];
    assign o_vga_blue    = out_rgb_q[RGB_BITWIDTH-1:0];
    assign o_vga_hsync   = out_hsync_q;
    assign o_vga_vsync   = out_vsync_q;
    assign o_visible     = out_vis_q;
    assign o_frame_start = out_fs_q;
endmodule

// File: tb/tb_vga_rect_compositor.sv
// Self-checking bench for vga_rect_compositor on a 10x8 raster: a behavioural
// raster/bank model feeds a scoreboard, plus per-scene pixel tables.
module tb_vga_rect_compositor;
    localparam int P    = 4;
    localparam int NR   = 2;
    localparam int IDXW = 1;
    localparam int DW   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rect_compositor_if #(.IDX_BITWIDTH(IDXW), .DATA_BITWIDTH(DW)) wb ();

    logic [P-1:0] o_vga_x, o_vga_y;
    logic [1:0]   o_vga_red, o_vga_green, o_vga_blue;
    logic         o_vga_hsync, o_vga_vsync, o_visible, o_frame_start;

    vga_rect_compositor #(
        .WIDTH(10), .HEIGHT(8), .WIDTH_VISIBLE(6), .HEIGHT_VISIBLE(4),
        .FRONT_PORCH_X(1), .BACK_PORCH_X(1), .FRONT_PORCH_Y(1), .BACK_PORCH_Y(1),
        .NUM_RECTS(NR), .PIXEL_BITWIDTH(P), .RGB_BITWIDTH(2)
    ) dut (
        .i_clk(clk), .i_reset(rst), .wr_bus(wb),
        .o_vga_x(o_vga_x), .o_vga_y(o_vga_y),
        .o_vga_red(o_vga_red), .o_vga_green(o_vga_green), .o_vga_blue(o_vga_blue),
        .o_vga_hsync(o_vga_hsync), .o_vga_vsync(o_vga_vsync),
        .o_visible(o_visible), .o_frame_start(o_frame_start)
    );

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] r, g, b;
        logic       hs, vs, vis, fs;
    } pix_t;

    typedef struct {
        int x, y, w, h, col;
        bit en;
    } mrect_t;

    typedef struct {
        int scene, x, y, rgb;
    } vec_t;

    int     n_checks = 0;
    int     n_errors = 0;
    mrect_t m_pend [NR];
    mrect_t m_act  [NR];
    int     m_pbg, m_abg, m_cx, m_cy;
    pix_t   exp_q [$];
    int     cyc = 0;
    int     last_fs = -1;
    vec_t   vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic pix_t dut_pix();
        pix_t p;
        p.x = o_vga_x; p.y = o_vga_y;
        p.r = o_vga_red; p.g = o_vga_green; p.b = o_vga_blue;
        p.hs = o_vga_hsync; p.vs = o_vga_vsync; p.vis = o_visible; p.fs = o_frame_start;
        return p;
    endfunction

    function automatic logic [5:0] dut_rgb();
        return {o_vga_red, o_vga_green, o_vga_blue};
    endfunction

    function automatic pix_t model_pix(input int cx, input int cy);
        pix_t p;
        int   col;
        bit   found;
        col   = m_abg;
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (!found && m_act[k].en && cx >= m_act[k].x && cx < m_act[k].x + m_act[k].w
                && cy >= m_act[k].y && cy < m_act[k].y + m_act[k].h) begin
                col   = m_act[k].col;
                found = 1'b1;
            end
        end
        p.vis = (cx < 6) && (cy < 4);
        if (!p.vis) col = 0;
        p.x  = cx[3:0];
        p.y  = cy[3:0];
        p.r  = col[5:4];
        p.g  = col[3:2];
        p.b  = col[1:0];
        p.hs = !(cx == 7 || cx == 8);
        p.vs = !(cy == 5 || cy == 6);
        p.fs = (cx == 0 && cy == 0);
        return p;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NR; k++) begin
            m_pend[k] = '{0, 0, 0, 0, 0, 1'b0};
            m_act[k]  = '{0, 0, 0, 0, 0, 1'b0};
        end
        m_pbg = 0; m_abg = 0; m_cx = 0; m_cy = 0;
        exp_q.delete();
        last_fs = -1;
    endtask

    task automatic model_edge();
        int f, r, d;
        if (m_cx == 9 && m_cy == 7) begin
            m_act = m_pend;
            m_abg = m_pbg;
        end
        if (wb.i_wr_en) begin
            f = int'(wb.i_wr_field);
            r = int'(wb.i_wr_rect);
            d = int'(wb.i_wr_data);
            if (f == 6) m_pbg = d;
            else if (r < NR) begin
                case (f)
                    0: m_pend[r].x   = d & 15;
                    1: m_pend[r].y   = d & 15;
                    2: m_pend[r].w   = d & 15;
                    3: m_pend[r].h   = d & 15;
                    4: m_pend[r].col = d;
                    5: m_pend[r].en  = d[0];
                    default: ;
                endcase
            end
        end
        if (m_cx == 9) begin
            m_cx = 0;
            m_cy = (m_cy == 7) ? 0 : m_cy + 1;
        end else m_cx = m_cx + 1;
    endtask

    task automatic tick();
        pix_t e;
        exp_q.push_back(model_pix(m_cx, m_cy));
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check("pix", dut_pix(), e);
        end
        if (o_frame_start) begin
            if (last_fs >= 0) check("fs_period", cyc - last_fs, 80);
            last_fs = cyc;
        end
    endtask

    task automatic wr(input int field, input int rect, input int data);
        wb.i_wr_en    = 1'b1;
        wb.i_wr_field = field[2:0];
        wb.i_wr_rect  = rect[0:0];
        wb.i_wr_data  = data[5:0];
        tick();
        wb.i_wr_en    = 1'b0;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_frame_start && n < 200);
        check("wait_fs", o_frame_start, 1);
    endtask

    task automatic wait_pixel(input int x, input int y);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(o_vga_x == x[3:0] && o_vga_y == y[3:0]) && n < 200);
        check("wait_pix", {o_vga_x, o_vga_y}, {x[3:0], y[3:0]});
    endtask

    task automatic pulse_reset(input string name);
        pix_t rp;
        rp = '{x: 4'd0, y: 4'd0, r: 2'd0, g: 2'd0, b: 2'd0, hs: 1'b1, vs: 1'b1, vis: 1'b0, fs: 1'b0};
        rst = 1'b1;
        model_clear();
        #1;
        check(name, dut_pix(), rp);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", dut_pix(), rp);
        end
        rst = 1'b0;
        tick();
        tick();
        check("first_fs", {o_frame_start, o_vga_x, o_vga_y}, {1'b1, 4'd0, 4'd0});
    endtask

    task automatic configure(input int scene);
        case (scene)
            1: begin
                wr(0, 0, 1); wr(1, 0, 1); wr(2, 0, 2); wr(3, 0, 2); wr(4, 0, 'h3F); wr(5, 0, 1);
            end
            2: begin
                wr(0, 1, 2); wr(1, 1, 2); wr(2, 1, 3); wr(3, 1, 1); wr(4, 1, 'h30); wr(5, 1, 1);
            end
            3: begin
                wr(5, 0, 0); wr(5, 1, 0); wr(6, 0, 'h15);
            end
            default: begin
                wr(0, 0, 14); wr(1, 0, 0); wr(2, 0, 5); wr(3, 0, 4); wr(5, 0, 1);
                wr(0, 1, 0);  wr(1, 1, 0); wr(2, 1, 0); wr(3, 1, 4); wr(5, 1, 1);
            end
        endcase
    endtask

    initial begin
        // Scene tables, each in raster order within one frame.
        vecs.push_back('{1, 1, 1, 'h3F}); vecs.push_back('{1, 2, 1, 'h3F});
        vecs.push_back('{1, 3, 1, 'h00}); vecs.push_back('{1, 0, 2, 'h00});
        vecs.push_back('{1, 1, 2, 'h3F}); vecs.push_back('{1, 2, 2, 'h3F});
        vecs.push_back('{1, 1, 3, 'h00});
        vecs.push_back('{2, 1, 1, 'h3F}); vecs.push_back('{2, 2, 2, 'h3F});
        vecs.push_back('{2, 3, 2, 'h30}); vecs.push_back('{2, 4, 2, 'h30});
        vecs.push_back('{2, 5, 2, 'h00});
        vecs.push_back('{3, 5, 0, 'h15}); vecs.push_back('{3, 6, 0, 'h00});
        vecs.push_back('{3, 9, 0, 'h00}); vecs.push_back('{3, 0, 3, 'h15});
        vecs.push_back('{3, 5, 3, 'h15}); vecs.push_back('{3, 0, 4, 'h00});
        vecs.push_back('{3, 3, 7, 'h00});
        vecs.push_back('{4, 1, 0, 'h15}); vecs.push_back('{4, 5, 0, 'h15});
        vecs.push_back('{4, 0, 1, 'h15}); vecs.push_back('{4, 5, 3, 'h15});

        wb.i_wr_en = 1'b0; wb.i_wr_rect = '0; wb.i_wr_field = '0; wb.i_wr_data = '0;
        @(posedge clk);
        #1;
        pulse_reset("reset_out");
        repeat (80) tick();

        for (int s = 1; s <= 4; s++) begin
            wait_fs();
            configure(s);
            if (s == 1) begin
                wait_pixel(1, 1);
                check("pre_commit", dut_rgb(), 'h00);
            end
            wait_fs();
            foreach (vecs[i]) begin
                if (vecs[i].scene == s) begin
                    wait_pixel(vecs[i].x, vecs[i].y);
                    check($sformatf("vec%0d_s%0d_(%0d,%0d)", i, s, vecs[i].x, vecs[i].y),
                          dut_rgb(), vecs[i].rgb[5:0]);
                end
            end
        end

        // A write landing on the last raster cycle must skip one frame.
        wait_fs();
        wr(5, 0, 0); wr(5, 1, 0); wr(6, 0, 0);
        wr(0, 0, 1); wr(1, 0, 1); wr(2, 0, 2); wr(3, 0, 2); wr(4, 0, 'h3F);
        wait_fs();
        for (int n = 0; n < 200 && !(m_cx == 9 && m_cy == 7); n++) tick();
        wr(5, 0, 1);
        wait_fs();
        wait_pixel(1, 1);
        check("late_absent", dut_rgb(), 'h00);
        wait_fs();
        wait_pixel(1, 1);
        check("late_present", dut_rgb(), 'h3F);

        // Mid-line reset wipes both banks.
        wait_pixel(3, 1);
        pulse_reset("midreset");
        wait_pixel(1, 1);
        check("after_reset", dut_rgb(), 'h00);
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vga_rect_compositor.md
# vga_rect_compositor

Multi-rectangle VGA compositor for the PPU video path. It generates its own VGA raster timing and draws up to NUM_RECTS filled, individually coloured rectangles over a programmable background colour, with fixed index priority. Rectangle parameters are written through a simple register port into a pending bank. The pending bank is copied to the active bank once per frame, so updates never tear. Outputs are pipelined, with x, y, RGB and syncs cycle-aligned.

## Interface
Parameters:
- WIDTH, 800: total clocks per line
- HEIGHT, 525: total lines per frame
- WIDTH_VISIBLE, 640: visible pixels per line
- HEIGHT_VISIBLE, 480: visible lines per frame
- FRONT_PORCH_X, 16 / BACK_PORCH_X, 48: horizontal porches; hsync width = WIDTH-WIDTH_VISIBLE-FRONT_PORCH_X-BACK_PORCH_X (must be ≥1)
- FRONT_PORCH_Y, 10 / BACK_PORCH_Y, 33: vertical porches; vsync width derived the same way (must be ≥1)
- NUM_RECTS, 4: rectangle count, ≥1; IDX_BITWIDTH = max(1, clog2(NUM_RECTS))
- PIXEL_BITWIDTH, 11: coordinate width
- RGB_BITWIDTH, 8: per-channel width; 3*RGB_BITWIDTH ≥ PIXEL_BITWIDTH required

Ports:
- i_clk  in  1  pixel clock
- i_reset  in  1  asynchronous, active-high reset
- i_wr_en  in  1  register write strobe, one write per cycle
- i_wr_rect  in  IDX_BITWIDTH  target rectangle; ignored for field 6
- i_wr_field  in  3  0=x, 1=y, 2=width, 3=height, 4=colour, 5=enable, 6=background colour, 7=reserved (write ignored)
- i_wr_data  in  3*RGB_BITWIDTH  colours {R,G,B} with R in the MSBs; coordinate fields use the low PIXEL_BITWIDTH bits; enable uses bit 0
- o_vga_x, o_vga_y  out  PIXEL_BITWIDTH  raster position of the current output pixel
- o_vga_red, o_vga_green, o_vga_blue  out  RGB_BITWIDTH  pixel colour
- o_vga_hsync, o_vga_vsync  out  1  active-low syncs
- o_visible  out  1  output pixel lies in the visible region
- o_frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- Raster counters cx, cy:
  - cx increments every cycle and wraps from WIDTH-1 to 0.
  - cy increments when cx wraps and wraps from HEIGHT-1 to 0.
- Pending bank: per rectangle x, y, w, h, colour, enable, plus one background colour.
  - A write updates the addressed field on the next edge.
  - Out-of-range i_wr_rect (≥NUM_RECTS) is ignored.
- Active bank commit:
  - When (cx,cy) = (WIDTH-1,HEIGHT-1), the active bank loads the pending bank on that edge, effective from raster (0,0).
  - The commit copies pending values as they are before that cycle's write. A write in the same cycle lands in pending only and commits one frame later.
- Hit test for rectangle k: enable_k && cx ≥ x_k && cy ≥ y_k && cx < x_k+w_k && cy < y_k+h_k.
  - Sums are computed at PIXEL_BITWIDTH+1 bits, with no wrap. A rectangle extending past 2^PIXEL_BITWIDTH is clipped, never wrapped.
  - w=0 or h=0 never hits.
- Colour selection:
  - The lowest-index hitting rectangle wins.
  - With no hit, the background colour is used.
  - Outside the visible region (cx ≥ WIDTH_VISIBLE or cy ≥ HEIGHT_VISIBLE), RGB is forced to 0.
- Syncs:
  - hsync is low for cx in [WIDTH_VISIBLE+FRONT_PORCH_X, WIDTH_VISIBLE+FRONT_PORCH_X+hsync width).
  - vsync is low for cy in the equivalent vertical window.
- Pipeline:
  - Stage 1 registers the hit vector, cx, cy, visible and syncs.
  - Stage 2 registers the priority-muxed colour and all outputs.
- Reset (asynchronous):
  - cx, cy, pipeline and both banks cleared: all enables 0, background 0.
  - Outputs: x=0, y=0, RGB=0, hsync=1, vsync=1, o_visible=0, o_frame_start=0.
  - Reset mid-frame restarts the raster at (0,0) with an empty display; there is no partial commit.

## Timing
- Latency is 2 cycles. Raster (cx,cy) at edge t appears on all outputs after edge t+2.
- Every output is registered, and all outputs are mutually aligned.
- After reset deasserts, the first output pixel (0,0) with o_frame_start=1 appears 2 cycles after the first active edge. o_frame_start is 0 during the reset cycles.
- Commit boundary: a write accepted at raster cycle (WIDTH-1,HEIGHT-1) of frame N is first visible in frame N+2. A write at any earlier cycle of frame N is first visible in frame N+1.
- Writes never alter the pixels of the frame in progress.

## Test plan
Bench parameters: WIDTH=10, HEIGHT=8, VIS 6×4, porches 1/1 both axes (sync width 2), NUM_RECTS=2, PIXEL_BITWIDTH=4, RGB_BITWIDTH=2.
- Reset then run 80 cycles:
  - RGB is 0 throughout.
  - hsync is low exactly at x=7,8 each line; vsync is low exactly at y=5,6.
  - o_frame_start pulses every 80 cycles, aligned with x=0,y=0.
- Rect0 configured as x=1,y=1,w=2,h=2, colour 0x3F, enabled during frame 0:
  - Frame 0 is all background.
  - Frame 1 shows RGB=3/3/3 exactly at (1..2,1..2) and 0 elsewhere.
- Rect0 as above plus rect1 at x=2,y=2,w=3,h=1, colour 0x30:
  - Pixel (2,2) shows rect0's colour (index priority).
  - (3,2) and (4,2) show R=3,G=0,B=0.
- Background 0x15, no rects:
  - Visible pixels show 1/1/1.
  - Pixels with x ≥ 6 or y ≥ 4 show 0.
- Rect0 x=14, w=5 (sum 19 > 15): hits only at x=14,15, which lie outside the visible region, so output shows background. Rect w=0 never hits.
- Write to enable rect0 at raster (9,7): absent in the next frame, present in the following one.
- Assert reset mid-line:
  - Outputs go to reset values within the same cycle.
  - Previously enabled rects are gone after release.
